// File: rtl/cpu_bus_responder_pkg.sv
// cpu_bus_responder_pkg
//   Shared definitions for the CPU bus responder:
//   - address window base/limit constants for RAM, PPU, APU/IO and PRG
//   - the OAM DMA page register ($4014) and PPU OAMDATA ($2004) addresses
//   - the OAM DMA state encoding
//   - in_window(): window match for power-of-two aligned regions
package cpu_bus_responder_pkg;

    localparam logic [15:0] RAM_BASE    = 16'h0000;
    localparam logic [15:0] RAM_LIMIT   = 16'h1FFF;
    localparam logic [15:0] PPU_BASE    = 16'h2000;
    localparam logic [15:0] PPU_LIMIT   = 16'h3FFF;
    localparam logic [15:0] IO_BASE     = 16'h4000;
    localparam logic [15:0] IO_LIMIT    = 16'h401F;
    localparam logic [15:0] PRG_BASE    = 16'h8000;
    localparam logic [15:0] PRG_LIMIT   = 16'hFFFF;

    localparam logic [15:0] OAM_DMA_REG = 16'h4014;
    localparam logic [15:0] OAMDATA_REG = 16'h2004;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_RD,
        DMA_WR
    } dma_state_e;

    // Every window is aligned, so the bits that vary inside it are base ^ limit.
    function automatic logic in_window(input logic [15:0] a,
                                       input logic [15:0] base,
                                       input logic [15:0] limit);
        return (a & ~(base ^ limit)) == base;
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// oam_dma_engine
//   OAM DMA sequencer: a trigger latches the source page, the CPU is halted,
//   an optional alignment cycle is inserted on odd parity, then 256 read/write
//   pairs copy {page, count} into the PPU OAMDATA register.
// Ports
//   clk_i    clock
//   rst_i    synchronous active-high reset (aborts any transfer)
//   start_i  CPU write to the page register accepted this cycle
//   page_i   page value written by the CPU
//   rdata_i  byte returned by the bus decode for the DMA read address
//   rdy_o    1 = CPU may run; 0 = DMA owns the bus
//   rd_o     DMA read cycle: addr_o drives the bus decode
//   wr_o     DMA write cycle: wdata_o goes to OAMDATA
//   addr_o   DMA source address {page, count}
//   wdata_o  byte captured in the last read cycle
module oam_dma_engine
    import cpu_bus_responder_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  page_i,
    input  logic [7:0]  rdata_i,
    output logic        rdy_o,
    output logic        rd_o,
    output logic        wr_o,
    output logic [15:0] addr_o,
    output logic [7:0]  wdata_o
);

    dma_state_e state_q, state_d;
    logic       parity_q;
    logic [7:0] page_q,  page_d;
    logic [7:0] count_q, count_d;
    logic [7:0] buf_q,   buf_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= DMA_IDLE;
            parity_q <= 1'b0;
            page_q   <= '0;
            count_q  <= '0;
            buf_q    <= '0;
        end else begin
            state_q  <= state_d;
            parity_q <= ~parity_q;
            page_q   <= page_d;
            count_q  <= count_d;
            buf_q    <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        count_d = count_q;
        buf_d   = buf_q;
        unique case (state_q)
            DMA_IDLE: begin
                if (start_i) begin
                    page_d  = page_i;
                    count_d = '0;
                    state_d = DMA_HALT;
                end
            end
            DMA_HALT:  state_d = parity_q ? DMA_ALIGN : DMA_RD;
            DMA_ALIGN: state_d = DMA_RD;
            DMA_RD: begin
                buf_d   = rdata_i;
                state_d = DMA_WR;
            end
            DMA_WR: begin
                count_d = count_q + 8'd1;
                state_d = (count_q == 8'hFF) ? DMA_IDLE : DMA_RD;
            end
            default: state_d = DMA_IDLE;
        endcase
    end

    assign rdy_o   = (state_q == DMA_IDLE);
    assign rd_o    = (state_q == DMA_RD);
    assign wr_o    = (state_q == DMA_WR);
    assign addr_o  = {page_q, count_q};
    assign wdata_o = buf_q;

endmodule

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
//   CPU bus target: decodes each access into work RAM (mirrored over
//   $0000-$1FFF), PPU registers, APU/IO registers, the OAM DMA page register
//   and PRG ROM, and runs OAM DMA via oam_dma_engine.
//   Build option: OPEN_BUS_EN -- unmapped reads leave cpu_data unchanged
//   instead of returning 8'h00.
// Ports
//   clk_ph2                 clock
//   rst                     synchronous active-high reset
//   cpu_addr/rw/wdata       CPU access request
//   cpu_data                registered read data
//   cpu_rdy                 0 = CPU stalled by OAM DMA
//   ppu_addr/we/re/wdata    PPU register port, ppu_rdata same-cycle data
//   io_addr/we/re/wdata     APU/IO register port, io_rdata same-cycle data
//   prg_addr                PRG ROM address, prg_rdata same-cycle data
module cpu_bus_responder
    import cpu_bus_responder_pkg::*;
#(
    parameter int unsigned RAM_AW = 11,
    parameter int unsigned PRG_AW = 15
) (
    input  logic              clk_ph2,
    input  logic              rst,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_rw,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_data,
    output logic              cpu_rdy,
    output logic [2:0]        ppu_addr,
    output logic              ppu_we,
    output logic              ppu_re,
    output logic [7:0]        ppu_wdata,
    input  logic [7:0]        ppu_rdata,
    output logic [4:0]        io_addr,
    output logic              io_we,
    output logic              io_re,
    output logic [7:0]        io_wdata,
    input  logic [7:0]        io_rdata,
    output logic [PRG_AW-1:0] prg_addr,
    input  logic [7:0]        prg_rdata
);

    logic        dma_rdy, dma_rd, dma_wr, dma_start;
    logic [15:0] dma_addr;
    logic [7:0]  dma_buf;

    logic        cpu_ok, dma_rd_g, dma_wr_g, acc, is_rd;
    logic        sel_ram, sel_ppu, sel_io, sel_reg, sel_prg, ram_we;
    logic [15:0] ea;
    logic [7:0]  rd_data, ram_rdata;
    logic [7:0]  cpu_data_q;
    logic [7:0]  ram_q [2**RAM_AW];

    oam_dma_engine u_dma (
        .clk_i   (clk_ph2),
        .rst_i   (rst),
        .start_i (dma_start),
        .page_i  (cpu_wdata),
        .rdata_i (rd_data),
        .rdy_o   (dma_rdy),
        .rd_o    (dma_rd),
        .wr_o    (dma_wr),
        .addr_o  (dma_addr),
        .wdata_o (dma_buf)
    );

    always_comb begin
        // Reset masks every access so no strobe or write escapes the abort cycle.
        dma_rd_g = dma_rd & ~rst;
        dma_wr_g = dma_wr & ~rst;
        cpu_ok   = dma_rdy & ~rst;
        ea       = dma_rd_g ? dma_addr : cpu_addr;
        acc      = cpu_ok | dma_rd_g;
        is_rd    = dma_rd_g | cpu_rw;

        sel_ram  = acc & in_window(ea, RAM_BASE, RAM_LIMIT);
        sel_ppu  = acc & in_window(ea, PPU_BASE, PPU_LIMIT);
        sel_io   = acc & in_window(ea, IO_BASE, IO_LIMIT) & (ea != OAM_DMA_REG);
        sel_reg  = acc & (ea == OAM_DMA_REG);
        sel_prg  = acc & in_window(ea, PRG_BASE, PRG_LIMIT);

        ram_rdata = ram_q[ea[RAM_AW-1:0]];

        if (sel_ram)      rd_data = ram_rdata;
        else if (sel_ppu) rd_data = ppu_rdata;
        else if (sel_io)  rd_data = io_rdata;
        else if (sel_prg) rd_data = prg_rdata;
        else begin
`ifdef OPEN_BUS_EN
            rd_data = cpu_data_q;
`else
            rd_data = '0;
`endif
        end

        ram_we    = sel_ram & ~is_rd;
        // A DMA read of $4014 has is_rd set, so only the CPU can trigger.
        dma_start = sel_reg & ~is_rd;
    end

    assign ppu_re    = sel_ppu & is_rd;
    assign ppu_we    = (sel_ppu & ~is_rd) | dma_wr_g;
    assign ppu_addr  = dma_wr_g ? OAMDATA_REG[2:0] : ea[2:0];
    assign ppu_wdata = dma_wr_g ? dma_buf : cpu_wdata;
    assign io_re     = sel_io & is_rd;
    assign io_we     = sel_io & ~is_rd;
    assign io_addr   = ea[4:0];
    assign io_wdata  = cpu_wdata;
    assign prg_addr  = ea[PRG_AW-1:0];
    assign cpu_rdy   = dma_rdy;
    assign cpu_data  = cpu_data_q;

    always_ff @(posedge clk_ph2) begin
        if (ram_we) ram_q[ea[RAM_AW-1:0]] <= cpu_wdata;
    end

    always_ff @(posedge clk_ph2) begin
        if (rst)                   cpu_data_q <= '0;
        else if (cpu_ok && cpu_rw) cpu_data_q <= rd_data;
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
module tb_cpu_bus_responder;

    logic        clk_ph2 = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rw = 1'b1;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_data;
    logic        cpu_rdy;
    logic [2:0]  ppu_addr;
    logic        ppu_we, ppu_re;
    logic [7:0]  ppu_wdata;
    logic [7:0]  ppu_rdata = '0;
    logic [4:0]  io_addr;
    logic        io_we, io_re;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata = '0;
    logic [14:0] prg_addr;
    logic [7:0]  prg_rdata = '0;

    int errors = 0;
    int checks = 0;
    logic [7:0] mem [2048];   // reference image of work RAM
    bit par;                  // reference parity of the current cycle

`ifdef OPEN_BUS_EN
    localparam bit OPEN_BUS = 1'b1;
`else
    localparam bit OPEN_BUS = 1'b0;
`endif

    always #5 clk_ph2 = ~clk_ph2;

    cpu_bus_responder #(.RAM_AW(11), .PRG_AW(15)) dut (
        .clk_ph2   (clk_ph2),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_rw    (cpu_rw),
        .cpu_wdata (cpu_wdata),
        .cpu_data  (cpu_data),
        .cpu_rdy   (cpu_rdy),
        .ppu_addr  (ppu_addr),
        .ppu_we    (ppu_we),
        .ppu_re    (ppu_re),
        .ppu_wdata (ppu_wdata),
        .ppu_rdata (ppu_rdata),
        .io_addr   (io_addr),
        .io_we     (io_we),
        .io_re     (io_re),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .prg_addr  (prg_addr),
        .prg_rdata (prg_rdata)
    );

    // Advance one clock; parity is cleared by reset and toggles otherwise.
    task automatic step();
        @(posedge clk_ph2);
        par = rst ? 1'b0 : ~par;
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic rw, input logic [7:0] wd);
        cpu_addr  = a;
        cpu_rw    = rw;
        cpu_wdata = wd;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(16'h2002, 1'b1, 8'h00);
        checks++;
        if ({ppu_re, ppu_we, io_re, io_we} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: got %b required 0000", {ppu_re, ppu_we, io_re, io_we});
        end
        step(); step();
        rst = 1'b0;
        drive(16'h0000, 1'b1, 8'h00);
        checks++;
        if (cpu_data !== 8'h00) begin
            errors++; $display("FAIL reset_cpu_data: got %h required 00", cpu_data);
        end
        checks++;
        if (cpu_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_cpu_rdy: got %b required 1", cpu_rdy);
        end
    endtask

    task automatic test_ram_mirror();
        logic [10:0] q [$];
        logic [15:0] a;
        logic [7:0]  d;
        drive(16'h0005, 1'b0, 8'hA5);
        checks++;
        if ({ppu_re, ppu_we, io_re, io_we} !== 4'b0000) begin
            errors++; $display("FAIL ram_no_strobe: got %b required 0000", {ppu_re, ppu_we, io_re, io_we});
        end
        step(); mem[5] = 8'hA5;
        drive(16'h1805, 1'b1, 8'h00);
        step();
        checks++;
        if (cpu_data !== 8'hA5) begin
            errors++; $display("FAIL ram_mirror_1805: got %h required a5", cpu_data);
        end
        for (int i = 0; i < 16; i++) begin
            a = 16'($urandom_range(0, 16'h1FFF));
            d = 8'($urandom);
            drive(a, 1'b0, d);
            step();
            mem[a[10:0]] = d;
            q.push_back(a[10:0]);
        end
        for (int i = 0; i < 16; i++) begin
            a = {3'b000, 2'($urandom), q[i]};
            drive(a, 1'b1, 8'h00);
            step();
            checks++;
            if (cpu_data !== mem[q[i]]) begin
                errors++; $display("FAIL ram_readback @%h: got %h required %h", a, cpu_data, mem[q[i]]);
            end
        end
    endtask

    task automatic test_ppu();
        logic [15:0] a;
        logic [7:0]  d;
        d = 8'($urandom);
        ppu_rdata = d;
        drive(16'h3FFA, 1'b1, 8'h00);
        checks++;
        if (ppu_re !== 1'b1 || ppu_addr !== 3'd2 || ppu_we !== 1'b0 || io_re !== 1'b0) begin
            errors++; $display("FAIL ppu_read_3ffa: re=%b addr=%0d we=%b io_re=%b required 1 2 0 0", ppu_re, ppu_addr, ppu_we, io_re);
        end
        step();
        checks++;
        if (cpu_data !== d) begin
            errors++; $display("FAIL ppu_read_data: got %h required %h", cpu_data, d);
        end
        drive(16'h2007, 1'b0, 8'h5A);
        checks++;
        if (ppu_we !== 1'b1 || ppu_addr !== 3'd7 || ppu_wdata !== 8'h5A || ppu_re !== 1'b0) begin
            errors++; $display("FAIL ppu_write_2007: we=%b addr=%0d data=%h required 1 7 5a", ppu_we, ppu_addr, ppu_wdata);
        end
        step();
        drive(16'h0005, 1'b1, 8'h00);
        checks++;
        if (ppu_we !== 1'b0 || ppu_re !== 1'b0) begin
            errors++; $display("FAIL ppu_strobe_one_cycle: we=%b re=%b required 0 0", ppu_we, ppu_re);
        end
        step();
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom_range(16'h2000, 16'h3FFF));
            d = 8'($urandom);
            ppu_rdata = d;
            drive(a, 1'b1, 8'h00);
            checks++;
            if (ppu_re !== 1'b1 || ppu_addr !== a[2:0]) begin
                errors++; $display("FAIL ppu_rand_read @%h: re=%b addr=%0d required 1 %0d", a, ppu_re, ppu_addr, a[2:0]);
            end
            step();
            checks++;
            if (cpu_data !== d) begin
                errors++; $display("FAIL ppu_rand_data @%h: got %h required %h", a, cpu_data, d);
            end
        end
    endtask

    task automatic test_io();
        logic [15:0] a;
        logic [7:0]  d;
        logic        rw;
        for (int i = 0; i < 10; i++) begin
            a = 16'(16'h4000 + $urandom_range(0, 31));
            if (a == 16'h4014) a = 16'h4015;
            rw = 1'($urandom);
            d  = 8'($urandom);
            io_rdata = d;
            drive(a, rw, d ^ 8'hFF);
            checks++;
            if (io_re !== rw || io_we !== ~rw || io_addr !== a[4:0] || ppu_re !== 1'b0 || ppu_we !== 1'b0) begin
                errors++; $display("FAIL io_strobe @%h rw=%b: re=%b we=%b addr=%h", a, rw, io_re, io_we, io_addr);
            end
            if (!rw) begin
                checks++;
                if (io_wdata !== (d ^ 8'hFF)) begin
                    errors++; $display("FAIL io_wdata @%h: got %h required %h", a, io_wdata, d ^ 8'hFF);
                end
            end
            step();
            if (rw) begin
                checks++;
                if (cpu_data !== d) begin
                    errors++; $display("FAIL io_read_data @%h: got %h required %h", a, cpu_data, d);
                end
            end
        end
    endtask

    task automatic test_prg();
        logic [15:0] a;
        logic [7:0]  d;
        for (int i = 0; i < 5; i++) begin
            a = (i == 0) ? 16'hFFFC : 16'($urandom_range(16'h8000, 16'hFFFF));
            d = 8'($urandom);
            prg_rdata = d;
            drive(a, 1'b1, 8'h00);
            checks++;
            if (prg_addr !== a[14:0]) begin
                errors++; $display("FAIL prg_addr @%h: got %h required %h", a, prg_addr, a[14:0]);
            end
            step();
            checks++;
            if (cpu_data !== d) begin
                errors++; $display("FAIL prg_data @%h: got %h required %h", a, cpu_data, d);
            end
        end
    endtask

    task automatic test_open_bus();
        logic [15:0] ua [3];
        logic [7:0]  expv;
        ua[0] = 16'h5000; ua[1] = 16'h4014; ua[2] = 16'($urandom_range(16'h4020, 16'h7FFF));
        for (int i = 0; i < 3; i++) begin
            ppu_rdata = 8'h3C;
            drive(16'h2000, 1'b1, 8'h00);
            step();
            drive(ua[i], 1'b1, 8'h00);
            checks++;
            if ({ppu_re, ppu_we, io_re, io_we} !== 4'b0000) begin
                errors++; $display("FAIL unmapped_strobes @%h: got %b required 0000", ua[i], {ppu_re, ppu_we, io_re, io_we});
            end
            step();
            expv = OPEN_BUS ? 8'h3C : 8'h00;
            checks++;
            if (cpu_data !== expv) begin
                errors++; $display("FAIL unmapped_read @%h: got %h required %h", ua[i], cpu_data, expv);
            end
        end
    endtask

    // Trigger a DMA from a RAM page and follow it to completion while the CPU
    // keeps issuing writes that must all be ignored.
    task automatic run_dma(input logic [7:0] page, output bit p_halt);
        int stall, pulses, exp_stall, stray;
        bit done;
        logic [10:0] idx;
        drive(16'h4014, 1'b0, page);
        step();
        p_halt    = par;
        exp_stall = 513 + int'(p_halt);
        stall = 0; pulses = 0; stray = 0; done = 1'b0;
        for (int c = 0; c < 700 && !done; c++) begin
            if (cpu_rdy === 1'b1) begin
                done = 1'b1;
            end else begin
                stall++;
                case (c % 4)
                    0:       drive(16'h4014, 1'b0, 8'h07);
                    1:       drive({page, 8'(c)}, 1'b0, 8'hEE);
                    2:       drive(16'h2003, 1'b0, 8'h11);
                    default: drive(16'h4000, 1'b0, 8'h22);
                endcase
                if (ppu_we === 1'b1) begin
                    idx = {page[2:0], 8'(pulses)};
                    checks++;
                    if (ppu_addr !== 3'd4 || ppu_wdata !== mem[idx]) begin
                        errors++; $display("FAIL dma_pulse %0d: addr=%0d data=%h required 4 %h", pulses, ppu_addr, ppu_wdata, mem[idx]);
                    end
                    pulses++;
                end
                if (io_we || io_re || ppu_re) stray++;
                step();
            end
        end
        drive(16'h0000, 1'b1, 8'h00);
        checks++;
        if (!done) begin
            errors++; $display("FAIL dma_timeout: cpu_rdy=%b after %0d cycles required 1", cpu_rdy, stall);
        end
        checks++;
        if (stall !== exp_stall) begin
            errors++; $display("FAIL dma_stall_len: got %0d required %0d", stall, exp_stall);
        end
        checks++;
        if (pulses !== 256) begin
            errors++; $display("FAIL dma_pulse_count: got %0d required 256", pulses);
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL dma_cpu_strobes: got %0d required 0", stray);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (cpu_rdy !== 1'b1) begin
                errors++; $display("FAIL dma_no_retrigger: cpu_rdy=%b required 1", cpu_rdy);
            end
        end
    endtask

    task automatic test_dma();
        bit p1, p2;
        logic [7:0] r, d;
        for (int i = 0; i < 256; i++) begin
            drive({8'h0A, 8'(i)}, 1'b0, 8'(i));
            mem[{3'd2, 8'(i)}] = 8'(i);
            step();
        end
        run_dma(8'h02, p1);
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom);
            drive({8'h1D, 8'(i)}, 1'b0, d);
            mem[{3'd5, 8'(i)}] = d;
            step();
        end
        // Make the second transfer start on the opposite parity.
        if ((~par) == p1) step();
        run_dma(8'h05, p2);
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom);
            drive({8'h02, r}, 1'b1, 8'h00);
            step();
            checks++;
            if (cpu_data !== mem[{3'd2, r}]) begin
                errors++; $display("FAIL dma_ram_untouched @02%h: got %h required %h", r, cpu_data, mem[{3'd2, r}]);
            end
        end
    endtask

    task automatic test_dma_reset();
        int bad;
        bit p;
        drive(16'h4014, 1'b0, 8'h05);
        step();
        for (int i = 0; i < 100; i++) begin
            drive(16'h0000, 1'b1, 8'h00);
            step();
        end
        rst = 1'b1;
        drive(16'h0000, 1'b1, 8'h00);
        checks++;
        if (ppu_we !== 1'b0) begin
            errors++; $display("FAIL dma_reset_cycle_we: got %b required 0", ppu_we);
        end
        step();
        rst = 1'b0;
        drive(16'h0000, 1'b1, 8'h00);
        checks++;
        if (cpu_rdy !== 1'b1) begin
            errors++; $display("FAIL dma_reset_rdy: got %b required 1", cpu_rdy);
        end
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            if (ppu_we !== 1'b0 || cpu_rdy !== 1'b1) bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL dma_reset_quiet: got %0d bad cycles required 0", bad);
        end
        run_dma(8'h05, p);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ram_mirror();
        test_ppu();
        test_io();
        test_prg();
        test_open_bus();
        test_dma();
        test_dma_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
